aes_encrypt_core: RTL
=====================

AES_ENCRYPT_CORE -- requirements
Module: aes_encrypt_core

Interface
REQ-001 The block SHALL have parameter TEXT_WIDTH, default 128, meaning the plaintext/cyphertext width; only 128 is supported.
REQ-002 The block SHALL have parameter KEY_WIDTH, default 128, meaning the cipher key width; only 128 (AES-128, 10 rounds) is supported.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock, with all flops on the rising edge.
REQ-005 The block SHALL have port rst_i, input, 1 bit: synchronous active-high reset.
REQ-006 The block SHALL have port start_i, input, 1 bit: request to encrypt, sampled only in IDLE.
REQ-007 The block SHALL have port plaintext_i, input, TEXT_WIDTH bits: the block to encrypt, sampled on accept.
REQ-008 The block SHALL have port key_i, input, KEY_WIDTH bits: the cipher key, sampled on accept.
REQ-009 The block SHALL have port busy_o, output, 1 bit: high while in state ROUND or DONE.
REQ-010 The block SHALL have port cyphertext_o, output, TEXT_WIDTH bits: the registered result, valid from the finish_o cycle onward.
REQ-011 The block SHALL have port finish_o, output, 1 bit: a one-cycle completion pulse.
REQ-012 The block SHALL have port round_o, output, 4 bits: the current round number, 0 when idle.

Function
REQ-013 Byte order SHALL be FIPS-197 column-major: bits [127:120] hold byte 0 (row 0, col 0), bits [119:112] hold byte 1 (row 1, col 0), and so on.
REQ-014 The FSM SHALL have states IDLE, ROUND and DONE, with transitions IDLE->ROUND on start_i, ROUND->ROUND while round < 10, ROUND->DONE on completing round 10, and DONE->IDLE unconditionally.
REQ-015 On accept (IDLE and start_i high, edge E0), the block SHALL load state <= plaintext_i ^ key_i, load rk <= key_i, set round <= 1 and go to ROUND.
REQ-016 At each edge in ROUND for round r (edges E1..E10), the block SHALL compute rk_next = KeyExpand(rk, Rcon[r]) and state <= MixColumns(ShiftRows(SubBytes(state))) ^ rk_next, then set rk <= rk_next and round <= r+1.
REQ-017 Round 10 SHALL omit MixColumns.
REQ-018 At E10 the block SHALL load cyphertext_o with the final state and go to DONE.
REQ-019 Rcon[1..10] SHALL be 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36 (hex), applied to the MSB byte of RotWord/SubWord of the word at bits [31:0].
REQ-020 KeyExpand SHALL implement w4 = w0 ^ SubWord(RotWord(w3)) ^ Rcon, w5 = w1 ^ w4, w6 = w2 ^ w5, w7 = w3 ^ w6.
REQ-021 MixColumns SHALL use the GF(2^8) polynomial 0x11B, with xtime(b) = (b<<1) ^ (b[7] ? 1B : 00), truncated to 8 bits.
REQ-022 The forward S-box SHALL be the standard FIPS-197 table, combinational, with 20 lookups per cycle (16 state, 4 key).
REQ-023 finish_o SHALL be high for exactly the one cycle in DONE (between E10 and E11), giving a latency of 11 cycles from the accept edge to the finish_o high cycle.
REQ-024 The next accept SHALL be possible at E12 at the earliest, giving a minimum issue interval of 12 cycles.
REQ-025 start_i SHALL be ignored in ROUND and DONE, with no queuing and no effect on the computation in progress.
REQ-026 plaintext_i and key_i SHALL be ignored after the accept edge, so changing them mid-operation does not alter the result.
REQ-027 cyphertext_o SHALL hold its value until the next completion and SHALL NOT change during a later operation until that operation's E10.
REQ-028 round_o SHALL equal round while in ROUND (1..10) and SHALL be 0 in IDLE and DONE.

Reset
REQ-029 When rst_i is high at a rising edge, the block SHALL set FSM = IDLE, busy_o = 0, finish_o = 0, round_o = 0, cyphertext_o = 0, and clear the internal state and rk registers to 0.
REQ-030 rst_i SHALL dominate start_i in the same cycle, so no accept occurs.
REQ-031 A reset mid-operation SHALL abort it, after which no finish_o pulse is produced for the aborted operation.
REQ-032 The block SHALL accept start_i in the first cycle after rst_i deasserts.

Verification
REQ-033 The bench SHALL cover: key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff, start pulse -> finish_o high 11 cycles later, cyphertext_o = 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-034 The bench SHALL cover: key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734 -> cyphertext_o = 3925841d02dc09fbdc118597196a0b32, and round_o stepping 1..10 then 0.
REQ-035 The bench SHALL cover: start_i held high continuously with vector REQ-033 -> a result every 12 cycles, finish_o exactly one cycle wide each time, identical cyphertext_o.
REQ-036 The bench SHALL cover: second start_i with different inputs at round 4, plus plaintext_i/key_i toggled mid-run -> result still matches REQ-033, no extra finish_o.
REQ-037 The bench SHALL cover: rst_i pulsed at round 5 -> busy_o = 0, round_o = 0, cyphertext_o = 0 next cycle, no finish_o; a new start with the REQ-034 vector then gives the correct result.
REQ-038 The bench SHALL cover: rst_i and start_i high together -> remains IDLE, busy_o = 0.

Source files
------------

// File: rtl/aes_encrypt_core.sv
// AES-128 encryption core: one round per clock, on-the-fly key expansion, 20 S-box lookups per cycle.
// Latency: finish_o is high in the 11th cycle counted from the accept cycle; next accept no earlier than 12 cycles after the previous one.
// Backpressure: none; start_i is sampled only in IDLE and ignored while busy, never queued.
module aes_encrypt_core #(
  parameter int TEXT_WIDTH = 128,
  parameter int KEY_WIDTH  = 128
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [TEXT_WIDTH-1:0] plaintext_i,
  input  logic [KEY_WIDTH-1:0]  key_i,
  output logic                  busy_o,
  output logic [TEXT_WIDTH-1:0] cyphertext_o,
  output logic                  finish_o,
  output logic [3:0]            round_o
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  // Forward S-box, byte 0x00 in the most significant position.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    sbox = SBOX_TBL[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  // SubBytes and ShiftRows fused: byte (row r, col c) comes from column (c+r)%4.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = sbox(s[127 - 8*(4*((c + r) % 4) + r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  fsm_t                  fsm_q, fsm_d;
  logic [TEXT_WIDTH-1:0] state_q, state_d;
  logic [KEY_WIDTH-1:0]  rk_q, rk_d;
  logic [3:0]            round_q, round_d;
  logic [TEXT_WIDTH-1:0] ct_q, ct_d;

  logic [31:0]  rot_w, w4, w5, w6, w7;
  logic [127:0] rk_next, sr_state, round_out;

  // Next round key and round result, computed from the current registers every cycle.
  always_comb begin
    rot_w   = {rk_q[23:0], rk_q[31:24]};
    w4      = rk_q[127:96] ^ {sbox(rot_w[31:24]) ^ rcon(round_q), sbox(rot_w[23:16]),
                              sbox(rot_w[15:8]), sbox(rot_w[7:0])};
    w5      = rk_q[95:64] ^ w4;
    w6      = rk_q[63:32] ^ w5;
    w7      = rk_q[31:0]  ^ w6;
    rk_next = {w4, w5, w6, w7};
    sr_state  = sub_shift(state_q);
    // The last round has no MixColumns.
    round_out = ((round_q == 4'd10) ? sr_state : mix_columns(sr_state)) ^ rk_next;
  end

  // FSM next-state and datapath register updates.
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rk_d    = rk_q;
    round_d = round_q;
    ct_d    = ct_q;
    case (fsm_q)
      IDLE: begin
        if (start_i) begin
          state_d = plaintext_i ^ key_i;
          rk_d    = key_i;
          round_d = 4'd1;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        state_d = round_out;
        rk_d    = rk_next;
        if (round_q == 4'd10) begin
          ct_d    = round_out;
          round_d = 4'd0;
          fsm_d   = DONE;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      DONE: begin
        fsm_d = IDLE;
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      rk_q    <= '0;
      round_q <= '0;
      ct_q    <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rk_q    <= rk_d;
      round_q <= round_d;
      ct_q    <= ct_d;
    end
  end

  assign busy_o       = (fsm_q == ROUND) || (fsm_q == DONE);
  assign finish_o     = (fsm_q == DONE);
  assign round_o      = (fsm_q == ROUND) ? round_q : 4'd0;
  assign cyphertext_o = ct_q;

endmodule
